// File: rtl/riscv_cpu_pkg.sv
// Shared types for the core's memory arbiter: FSM state and port-owner encodings.
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PEND = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch and LSU.
// Optional MEM_ARB_ROUND_ROBIN_EN: tie goes to the port that did not win the last grant.
module mem_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  arb_owner_e winner;
  arb_owner_e sel;
  logic       gnt_fwd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q;

  always_comb begin
    winner = OWN_NONE;
    if (instr_req_i && data_req_i) winner = last_data_q ? OWN_INSTR : OWN_DATA;
    else if (data_req_i)           winner = OWN_DATA;
    else if (instr_req_i)          winner = OWN_INSTR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      last_data_q <= 1'b0;
    else if (gnt_fwd) last_data_q <= (sel == OWN_DATA);
  end
`else
  // Data wins ties so a stalled LSU can never be starved by continuous fetch.
  always_comb begin
    winner = OWN_NONE;
    if (data_req_i)       winner = OWN_DATA;
    else if (instr_req_i) winner = OWN_INSTR;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    sel            = OWN_NONE;
    gnt_fwd        = 1'b0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;

    unique case (state_q)
      ARB_IDLE: sel = winner;
      ARB_PEND: sel = owner_q;
      default:  sel = OWN_NONE;
    endcase

    unique case (sel)
      OWN_INSTR: begin
        mem_req_o  = 1'b1;
        mem_addr_o = instr_addr_i;
        mem_be_o   = '1;
      end
      OWN_DATA: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
      default: ;
    endcase

    gnt_fwd     = mem_req_o && mem_gnt_i;
    instr_gnt_o = gnt_fwd && (sel == OWN_INSTR);
    data_gnt_o  = gnt_fwd && (sel == OWN_DATA);

    unique case (state_q)
      ARB_IDLE: begin
        if (sel != OWN_NONE) begin
          owner_d = sel;
          state_d = gnt_fwd ? ARB_BUSY : ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (gnt_fwd) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (owner_q == OWN_INSTR) instr_rdata_o = mem_rdata_i;
        if (owner_q == OWN_DATA)  data_rdata_o  = mem_rdata_i;
        if (mem_rvalid_i) begin
          instr_rvalid_o = (owner_q == OWN_INSTR);
          data_rvalid_o  = (owner_q == OWN_DATA);
          state_d        = ARB_IDLE;
          owner_d        = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_req_held_in_pend: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ARB_PEND) |-> ((owner_q == OWN_INSTR) ? instr_req_i : data_req_i));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  import riscv_cpu_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic [AW-1:0] data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_addr_i = '0; data_we_i = 0; data_be_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 0;
    repeat (2) tick();
    n_cmp++; if ({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, mem_we_o} !== 6'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, mem_we_o}); end
    n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o, instr_rdata_o, data_rdata_o} !== '0)
      begin n_fail++; $display("FAIL reset_bus: addr=%h be=%h wdata=%h want 0", mem_addr_o, mem_be_o, mem_wdata_o); end
    n_cmp++; if (dut.state_q !== ARB_IDLE)
      begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst_ni = 1;
    tick();
  endtask

  task automatic test_instr_only();
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    settle();
    n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o} !== 8'b1_0_1111_1_0)
      begin n_fail++; $display("FAIL instr_t0_ctrl: got %b want 10111110", {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o}); end
    n_cmp++; if (mem_addr_o !== 32'h100 || mem_wdata_o !== 32'h0)
      begin n_fail++; $display("FAIL instr_t0_addr: addr=%h wdata=%h want 100/0", mem_addr_o, mem_wdata_o); end
    tick();
    instr_req_i = 0; mem_gnt_i = 0;
    settle();
    n_cmp++; if (mem_req_o !== 0 || instr_rvalid_o !== 0)
      begin n_fail++; $display("FAIL instr_t1: req=%b rvalid=%b want 0/0", mem_req_o, instr_rvalid_o); end
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
    settle();
    n_cmp++; if (instr_rvalid_o !== 1 || instr_rdata_o !== 32'h13)
      begin n_fail++; $display("FAIL instr_t2_resp: rvalid=%b rdata=%h want 1/00000013", instr_rvalid_o, instr_rdata_o); end
    n_cmp++; if (data_rvalid_o !== 0 || data_rdata_o !== 32'h0)
      begin n_fail++; $display("FAIL instr_t2_other: rvalid=%b rdata=%h want 0/0", data_rvalid_o, data_rdata_o); end
    tick();
    mem_rvalid_i = 0; mem_rdata_i = '0;
    settle();
    n_cmp++; if (dut.state_q !== ARB_IDLE || instr_rvalid_o !== 0)
      begin n_fail++; $display("FAIL instr_t3: state=%0d rvalid=%b want IDLE/0", dut.state_q, instr_rvalid_o); end
  endtask

  task automatic test_tie_store();
    instr_req_i = 1; instr_addr_i = 32'h104;
    data_req_i = 1; data_addr_i = 32'h2000; data_we_i = 1; data_be_i = 4'hF; data_wdata_i = 32'hDEADBEEF;
    mem_gnt_i = 1;
    settle();
    n_cmp++; if ({mem_we_o, mem_be_o, data_gnt_o, instr_gnt_o} !== 7'b1_1111_1_0)
      begin n_fail++; $display("FAIL tie_ctrl: got %b want 1111110", {mem_we_o, mem_be_o, data_gnt_o, instr_gnt_o}); end
    n_cmp++; if (mem_addr_o !== 32'h2000 || mem_wdata_o !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL tie_fields: addr=%h wdata=%h want 2000/deadbeef", mem_addr_o, mem_wdata_o); end
    tick();
    data_req_i = 0; data_we_i = 0;
    settle();
    n_cmp++; if (instr_gnt_o !== 0 || mem_req_o !== 0)
      begin n_fail++; $display("FAIL tie_busy_gnt: instr_gnt=%b mem_req=%b want 0/0", instr_gnt_o, mem_req_o); end
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1;
    settle();
    n_cmp++; if ({data_rvalid_o, instr_rvalid_o, instr_gnt_o} !== 3'b100)
      begin n_fail++; $display("FAIL tie_resp: got %b want 100", {data_rvalid_o, instr_rvalid_o, instr_gnt_o}); end
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 1;
    settle();
    n_cmp++; if (instr_gnt_o !== 1 || mem_addr_o !== 32'h104 || mem_we_o !== 0)
      begin n_fail++; $display("FAIL tie_instr_next: gnt=%b addr=%h we=%b want 1/104/0", instr_gnt_o, mem_addr_o, mem_we_o); end
    tick();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    arb_owner_e exp [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp = '{OWN_DATA, OWN_INSTR, OWN_DATA, OWN_INSTR};
`else
    exp = '{OWN_DATA, OWN_DATA, OWN_DATA, OWN_DATA};
`endif
    test_reset();
    for (int i = 0; i < 4; i++) begin
      instr_req_i = 1; instr_addr_i = 32'h200; data_req_i = 1; data_addr_i = 32'h3000; data_be_i = 4'h3;
      mem_gnt_i = 1; mem_rvalid_i = 0;
      settle();
      n_cmp++; if ({instr_gnt_o, data_gnt_o} !== {exp[i] == OWN_INSTR, exp[i] == OWN_DATA})
        begin n_fail++; $display("FAIL b2b_gnt[%0d]: instr/data gnt=%b%b want owner %0d", i, instr_gnt_o, data_gnt_o, exp[i]); end
      tick();
      if (exp[i] == OWN_INSTR) instr_req_i = 0; else data_req_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA0 + i;
      settle();
      n_cmp++; if ({instr_rvalid_o, data_rvalid_o} !== {exp[i] == OWN_INSTR, exp[i] == OWN_DATA})
        begin n_fail++; $display("FAIL b2b_rvalid[%0d]: instr/data rvalid=%b%b want owner %0d", i, instr_rvalid_o, data_rvalid_o, exp[i]); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_gnt_stall();
    instr_req_i = 1; instr_addr_i = 32'h300;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req_i = 1; data_addr_i = 32'h400; end
      settle();
      n_cmp++; if (mem_req_o !== 1 || mem_addr_o !== 32'h300 || instr_gnt_o !== 0 || data_gnt_o !== 0)
        begin n_fail++; $display("FAIL stall[%0d]: req=%b addr=%h gnt=%b%b want 1/300/00", c, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o); end
      tick();
    end
    mem_gnt_i = 1;
    settle();
    n_cmp++; if (instr_gnt_o !== 1 || data_gnt_o !== 0 || mem_addr_o !== 32'h300)
      begin n_fail++; $display("FAIL stall_gnt: instr=%b data=%b addr=%h want 1/0/300", instr_gnt_o, data_gnt_o, mem_addr_o); end
    tick();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 1;
    settle();
    n_cmp++; if (data_gnt_o !== 1 || mem_addr_o !== 32'h400)
      begin n_fail++; $display("FAIL stall_data_after: gnt=%b addr=%h want 1/400", data_gnt_o, mem_addr_o); end
    tick();
    data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_stray_response();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55AA55AA;
    settle();
    n_cmp++; if (instr_rvalid_o !== 0 || data_rvalid_o !== 0 || instr_rdata_o !== 0 || data_rdata_o !== 0)
      begin n_fail++; $display("FAIL stray_rvalid: rvalid=%b%b rdata=%h/%h want 0", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o); end
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (dut.state_q !== ARB_IDLE)
      begin n_fail++; $display("FAIL stray_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_reset_in_busy();
    data_req_i = 1; data_addr_i = 32'h500; data_we_i = 0; data_be_i = 4'hF; mem_gnt_i = 1;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (dut.state_q !== ARB_BUSY)
      begin n_fail++; $display("FAIL rib_busy: got %0d want BUSY", dut.state_q); end
    rst_ni = 0;
    settle();
    n_cmp++; if ({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, mem_we_o, mem_be_o} !== 10'b0 || mem_addr_o !== 0)
      begin n_fail++; $display("FAIL rib_outputs: ctrl=%b addr=%h want 0", {instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, mem_we_o, mem_be_o}, mem_addr_o); end
    tick();
    rst_ni = 1;
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
    settle();
    n_cmp++; if (data_rvalid_o !== 0 || instr_rvalid_o !== 0 || data_rdata_o !== 0)
      begin n_fail++; $display("FAIL rib_stale: rvalid=%b%b rdata=%h want 0", instr_rvalid_o, data_rvalid_o, data_rdata_o); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1;
    #2;
    test_reset();
    test_instr_only();
    test_tie_store();
    test_back_to_back();
    test_gnt_stall();
    test_stray_response();
    test_reset_in_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded 100000ns want completion");
    $fatal(1);
  end

endmodule
